// File: rtl/input_port_router_if.sv
// Upstream/downstream signal bundle for input_port_router.
// master: packet source plus downstream arbiter side (drives *In, stallIn).
// slave : the router itself (drives inputReady, select bits and *Out).
// Widths come from NETWORK_ADDRESS_WIDTH, CACHE_BANK_ADDRESS_WIDTH and DATA_WIDTH,
// which get defaults here when not supplied by the build.
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface input_port_router_if;
  localparam int NAW = `NETWORK_ADDRESS_WIDTH;
  localparam int CBW = `CACHE_BANK_ADDRESS_WIDTH;
  localparam int DW  = `DATA_WIDTH;

  // upstream packet
  logic [NAW+CBW-1:0] destinationAddressIn;
  logic [NAW-1:0]     requesterAddressIn;
  logic               readIn;
  logic               writeIn;
  logic [DW-1:0]      dataIn;
  logic               inputReady;

  // downstream arbiters: {CACHE,WEST,EAST,SOUTH,NORTH}
  logic [4:0]         stallIn;
  logic               selectBit_NORTH;
  logic               selectBit_SOUTH;
  logic               selectBit_EAST;
  logic               selectBit_WEST;
  logic               selectBit_CACHE;
  logic [NAW+CBW-1:0] destinationAddressOut;
  logic [NAW-1:0]     requesterAddressOut;
  logic               readOut;
  logic               writeOut;
  logic [DW-1:0]      dataOut;

  modport master (
    output destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn, stallIn,
    input  inputReady, selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST,
           selectBit_CACHE, destinationAddressOut, requesterAddressOut, readOut, writeOut,
           dataOut
  );

  modport slave (
    input  destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn, stallIn,
    output inputReady, selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST,
           selectBit_CACHE, destinationAddressOut, requesterAddressOut, readOut, writeOut,
           dataOut
  );
endinterface

// File: rtl/input_port_router.sv
// Network input port: buffers incoming packets in a FIFO, computes the XY route
// at enqueue time and presents the head packet with a one-hot route select to
// the five output arbiters. The head pops when its own route is not stalled.
// Optional feature macro: INPUT_PORT_STATS_EN adds saturating acceptCount and
// stallCount outputs.
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module input_port_router #(
  parameter int FIFO_DEPTH = 4,
  parameter int X_WIDTH    = `NETWORK_ADDRESS_WIDTH / 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [`NETWORK_ADDRESS_WIDTH-1:0] localAddress,
  input_port_router_if.slave                bus
`ifdef INPUT_PORT_STATS_EN
  ,
  output logic [15:0]                       acceptCount,
  output logic [15:0]                       stallCount
`endif
);

  localparam int NAW     = `NETWORK_ADDRESS_WIDTH;
  localparam int CBW     = `CACHE_BANK_ADDRESS_WIDTH;
  localparam int DW      = `DATA_WIDTH;
  localparam int DAW     = NAW + CBW;
  localparam int Y_WIDTH = NAW - X_WIDTH;
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;

  // one-hot route, bit order matches stallIn {CACHE,WEST,EAST,SOUTH,NORTH}
  typedef enum logic [4:0] {
    ROUTE_NORTH = 5'b00001,
    ROUTE_SOUTH = 5'b00010,
    ROUTE_EAST  = 5'b00100,
    ROUTE_WEST  = 5'b01000,
    ROUTE_CACHE = 5'b10000
  } route_e;

  typedef struct packed {
    route_e           route;
    logic             rd;
    logic             wr;
    logic [DAW-1:0]   dest;
    logic [NAW-1:0]   req;
    logic [DW-1:0]    data;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            full, empty, input_ready;
  logic            push, pop, head_blocked;
  route_e          enq_route;
  entry_t          enq_entry, head, head_out;

  logic [NAW-1:0]     dst_net;
  logic [X_WIDTH-1:0] dst_x, loc_x;
  logic [Y_WIDTH-1:0] dst_y, loc_y;

  assign dst_net = bus.destinationAddressIn[DAW-1:CBW];
  assign dst_x   = dst_net[X_WIDTH-1:0];
  assign dst_y   = dst_net[NAW-1:X_WIDTH];
  assign loc_x   = localAddress[X_WIDTH-1:0];
  assign loc_y   = localAddress[NAW-1:X_WIDTH];

  // XY dimension-order route of the incoming packet: resolve X first, then Y
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    enq_route = ROUTE_CACHE;
    if (dst_x > loc_x)      enq_route = ROUTE_EAST;
    else if (dst_x < loc_x) enq_route = ROUTE_WEST;
    else if (dst_y > loc_y) enq_route = ROUTE_SOUTH;
    else if (dst_y < loc_y) enq_route = ROUTE_NORTH;
  end

  // Handshake, pop decision and next pointer/occupancy state
  always_comb begin
    full         = (count_q == CW'(FIFO_DEPTH));
    empty        = (count_q == '0);
    // reset gates ready directly so it drops the instant reset asserts
    input_ready  = reset & ~full;
    push         = (bus.readIn | bus.writeIn) & input_ready;
    head         = mem_q[rd_ptr_q];
    head_blocked = ~empty & (|(head.route & bus.stallIn));
    pop          = ~empty & ~head_blocked;

    enq_entry.route = enq_route;
    enq_entry.rd    = bus.readIn;
    enq_entry.wr    = bus.writeIn;
    enq_entry.dest  = bus.destinationAddressIn;
    enq_entry.req   = bus.requesterAddressIn;
    enq_entry.data  = bus.dataIn;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage, written at the tail on every accepted packet
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; entries are only ever observed while count marks them valid.
    if (push) mem_q[wr_ptr_q] <= enq_entry;
  end

  // Head packet presented to all arbiters; zeroed while the FIFO is empty
  always_comb begin
    head_out = '0;
    if (!empty) head_out = head;
  end

  assign bus.inputReady            = input_ready;
  assign bus.selectBit_NORTH       = head_out.route[0];
  assign bus.selectBit_SOUTH       = head_out.route[1];
  assign bus.selectBit_EAST        = head_out.route[2];
  assign bus.selectBit_WEST        = head_out.route[3];
  assign bus.selectBit_CACHE       = head_out.route[4];
  assign bus.readOut               = head_out.rd;
  assign bus.writeOut              = head_out.wr;
  assign bus.destinationAddressOut = head_out.dest;
  assign bus.requesterAddressOut   = head_out.req;
  assign bus.dataOut               = head_out.data;

`ifdef INPUT_PORT_STATS_EN
  logic [15:0] accept_count_q, accept_count_d;
  logic [15:0] stall_count_q,  stall_count_d;

  // Saturating event counters: accepted packets and blocked-head cycles
  always_comb begin
    accept_count_d = accept_count_q;
    stall_count_d  = stall_count_q;
    if (push && (accept_count_q != 16'hFFFF))       accept_count_d = accept_count_q + 16'd1;
    if (head_blocked && (stall_count_q != 16'hFFFF)) stall_count_d  = stall_count_q + 16'd1;
  end

  // Counter registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accept_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      accept_count_q <= accept_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign acceptCount = accept_count_q;
  assign stallCount  = stall_count_q;
`endif

endmodule

// File: tb/tb_input_port_router.sv
// Self-checking bench for input_port_router: directed routing, full, selective
// stall, push/pop wrap, mid-operation reset and (with INPUT_PORT_STATS_EN) the
// statistics counters, followed by a randomized run, all compared against a
// queue-based reference model.
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_input_port_router;
  localparam int NAW   = `NETWORK_ADDRESS_WIDTH;
  localparam int CBW   = `CACHE_BANK_ADDRESS_WIDTH;
  localparam int DW    = `DATA_WIDTH;
  localparam int DAW   = NAW + CBW;
  localparam int XW    = NAW / 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic           rd;
    logic           wr;
    logic [DAW-1:0] dest;
    logic [NAW-1:0] req;
    logic [DW-1:0]  data;
    logic [4:0]     route;
  } pkt_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NAW-1:0] loc_addr = 4'b0101;
`ifdef INPUT_PORT_STATS_EN
  logic [15:0]    accept_count, stall_count;
`endif

  pkt_t q[$];
  int   total = 0;
  int   bad = 0;
  int   mdl_acc = 0;
  int   mdl_stall = 0;

  input_port_router_if bus();

  input_port_router #(.FIFO_DEPTH(DEPTH), .X_WIDTH(XW)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .localAddress (loc_addr),
    .bus          (bus)
`ifdef INPUT_PORT_STATS_EN
    ,
    .acceptCount  (accept_count),
    .stallCount   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // XY routing computed from coordinates with plain arithmetic
  function automatic logic [4:0] ref_route(input int dnet, input int lnet);
    int dx, dy, lx, ly;
    dx = dnet % (1 << XW);
    dy = dnet / (1 << XW);
    lx = lnet % (1 << XW);
    ly = lnet / (1 << XW);
    if (dx > lx) return 5'b00100;
    if (dx < lx) return 5'b01000;
    if (dy > ly) return 5'b00010;
    if (dy < ly) return 5'b00001;
    return 5'b10000;
  endfunction

  function automatic logic [63:0] obs_sel();
    return 64'({bus.selectBit_CACHE, bus.selectBit_WEST, bus.selectBit_EAST,
                bus.selectBit_SOUTH, bus.selectBit_NORTH});
  endfunction

  function automatic logic [63:0] obs_pkt();
    return 64'({bus.readOut, bus.writeOut, bus.destinationAddressOut,
                bus.requesterAddressOut, bus.dataOut});
  endfunction

  task automatic check_outputs(input string tag);
    logic [63:0] exp_sel, exp_pkt;
    exp_sel = '0;
    exp_pkt = '0;
    if (q.size() != 0) begin
      exp_sel = 64'(q[0].route);
      exp_pkt = 64'({q[0].rd, q[0].wr, q[0].dest, q[0].req, q[0].data});
    end
    check({tag, "_rdy"}, 64'(bus.inputReady), 64'(q.size() < DEPTH));
    check({tag, "_sel"}, obs_sel(), exp_sel);
    check({tag, "_pkt"}, obs_pkt(), exp_pkt);
  endtask

  // One clock: present inputs, predict push/pop from the model, then compare
  task automatic cycle(input string tag, input logic rd, input logic wr,
                       input logic [NAW-1:0] dnet, input logic [DW-1:0] dat,
                       input logic [4:0] st);
    pkt_t p;
    bit   do_push, do_pop;
    p.rd    = rd;
    p.wr    = wr;
    p.dest  = {dnet, CBW'(dat)};
    p.req   = dnet ^ NAW'(dat);
    p.data  = dat;
    p.route = ref_route(int'(dnet), int'(loc_addr));
    bus.readIn               = rd;
    bus.writeIn              = wr;
    bus.destinationAddressIn = p.dest;
    bus.requesterAddressIn   = p.req;
    bus.dataIn               = dat;
    bus.stallIn              = st;
    do_push = (rd || wr) && (q.size() < DEPTH);
    do_pop  = (q.size() != 0) && ((q[0].route & st) == 5'b0);
    if (q.size() != 0 && !do_pop) mdl_stall++;
    if (do_push) mdl_acc++;
    @(posedge clk);
    if (do_pop) q.delete(0);
    if (do_push) q.push_back(p);
    #1;
    check_outputs(tag);
  endtask

  task automatic push_pkt(input string tag, input logic [NAW-1:0] dnet,
                          input logic [DW-1:0] dat, input logic [4:0] st);
    cycle(tag, 1'b1, 1'b0, dnet, dat, st);
  endtask

  task automatic idle(input string tag, input logic [4:0] st);
    cycle(tag, 1'b0, 1'b0, '0, '0, st);
  endtask

  // Assert reset between edges, confirm the immediate effect, release it
  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_async_sel"}, obs_sel(), 64'd0);
    check({tag, "_async_rw"}, 64'({bus.readOut, bus.writeOut}), 64'd0);
    check({tag, "_async_rdy"}, 64'(bus.inputReady), 64'd0);
    bus.readIn = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hold_sel"}, obs_sel(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.readIn = 1'b0;
    q.delete();
    mdl_acc = 0;
    mdl_stall = 0;
    #1;
    check({tag, "_rel_rdy"}, 64'(bus.inputReady), 64'd1);
    check({tag, "_rel_pkt"}, obs_pkt(), 64'd0);
  endtask

  initial begin
    logic [NAW-1:0] route_dst [5];
    logic [4:0]     route_exp [5];
    logic [1:0]     rw;

    route_dst[0] = 4'b0111; route_exp[0] = 5'b00100;
    route_dst[1] = 4'b0100; route_exp[1] = 5'b01000;
    route_dst[2] = 4'b1101; route_exp[2] = 5'b00010;
    route_dst[3] = 4'b0001; route_exp[3] = 5'b00001;
    route_dst[4] = 4'b0101; route_exp[4] = 5'b10000;

    bus.readIn = 1'b0;
    bus.writeIn = 1'b0;
    bus.destinationAddressIn = '0;
    bus.requesterAddressIn = '0;
    bus.dataIn = '0;
    bus.stallIn = '0;

    // reset state
    #2;
    check("por_sel", obs_sel(), 64'd0);
    check("por_rdy", 64'(bus.inputReady), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("por_rel_rdy", 64'(bus.inputReady), 64'd1);
    check("por_rel_pkt", obs_pkt(), 64'd0);

    // XY routing, one push per cycle, each visible one cycle later
    for (int i = 0; i < 5; i++) begin
      push_pkt("route", route_dst[i], DW'(8'h20 + i), 5'b00000);
      check("route_onehot", obs_sel(), 64'(route_exp[i]));
    end
    idle("route_drain", 5'b00000);

    // both flags pass through together
    cycle("rw_both", 1'b1, 1'b1, 4'b0111, 8'h3c, 5'b00000);
    check("rw_both_flags", 64'({bus.readOut, bus.writeOut}), 64'd3);
    idle("rw_drain", 5'b00000);

    // full: all routes stalled, 4 pushes, 5th refused, then drain in order
    for (int i = 1; i <= 4; i++) push_pkt("full_fill", 4'b0111, DW'(i), 5'b11111);
    check("full_rdy_low", 64'(bus.inputReady), 64'd0);
    push_pkt("full_fifth", 4'b0111, DW'(5), 5'b11111);
    check("full_head_kept", 64'(bus.dataOut), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      idle("full_drain", 5'b00000);
      check("full_order", 64'(bus.dataOut), 64'(i));
    end
    idle("full_last", 5'b00000);
    check("full_empty_sel", obs_sel(), 64'd0);

    // selective stall: EAST head blocked, NORTH behind it not shown
    push_pkt("sel_east", 4'b0111, 8'h41, 5'b00100);
    push_pkt("sel_north", 4'b0001, 8'h42, 5'b00100);
    for (int i = 0; i < 3; i++) begin
      idle("sel_hold", 5'b00100);
      check("sel_hold_east", obs_sel(), 64'(5'b00100));
      check("sel_hold_data", 64'(bus.dataOut), 64'h41);
    end
    idle("sel_pop_east", 5'b00000);
    check("sel_then_north", obs_sel(), 64'(5'b00001));
    idle("sel_pop_north", 5'b00000);
    check("sel_empty", obs_sel(), 64'd0);

    // simultaneous push/pop at count 2 over 10 cycles, wrapping pointers
    push_pkt("pp_fill", 4'b0111, 8'd100, 5'b11111);
    push_pkt("pp_fill", 4'b0111, 8'd101, 5'b11111);
    for (int k = 1; k <= 10; k++) begin
      push_pkt("pp_run", 4'b0111, DW'(101 + k), 5'b00000);
      check("pp_order", 64'(bus.dataOut), 64'(100 + k));
      check("pp_ready", 64'(bus.inputReady), 64'd1);
    end
    idle("pp_drain", 5'b00000);
    check("pp_drain_last", 64'(bus.dataOut), 64'd111);
    idle("pp_drain", 5'b00000);

    // reset mid-operation with 3 entries buffered
    for (int i = 0; i < 3; i++) push_pkt("rst_fill", 4'b1101, DW'(8'h50 + i), 5'b11111);
    do_reset("rst_mid");
    push_pkt("rst_after", 4'b0100, 8'h66, 5'b00000);
    check("rst_after_route", obs_sel(), 64'(5'b01000));
    idle("rst_after_drain", 5'b00000);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) loc_addr = NAW'($urandom_range(0, (1 << NAW) - 1));
      rw = ($urandom_range(0, 3) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle("rand", rw[1], rw[0], NAW'($urandom), DW'($urandom),
            5'($urandom & $urandom));
    end
    loc_addr = 4'b0101;

`ifdef INPUT_PORT_STATS_EN
    do_reset("stats_rst");
    check("stats_clr_acc", 64'(accept_count), 64'd0);
    check("stats_clr_stall", 64'(stall_count), 64'd0);
    for (int i = 0; i < 5; i++) push_pkt("stats_push", 4'b0111, DW'(i), 5'b00000);
    for (int i = 0; i < 7; i++) idle("stats_block", 5'b11111);
    check("stats_acc5", 64'(accept_count), 64'd5);
    check("stats_stall7", 64'(stall_count), 64'd7);
    check("stats_model_acc", 64'(accept_count), 64'(mdl_acc));
    check("stats_model_stall", 64'(stall_count), 64'(mdl_stall));
    for (int i = 0; i < 70000; i++) push_pkt("stats_sat", 4'b0111, DW'(i), 5'b00000);
    check("stats_acc_sat", 64'(accept_count), 64'hFFFF);
    check("stats_stall_kept", 64'(stall_count), 64'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
